// File: rtl/hog_engine_arbiter.sv
// hog_engine_arbiter: round-robin, frame-granular sharing of one hog_svm engine between
// REQ_AMT cell streams. Define HOG_ARB_TIMEOUT_EN to abort frames that stall for TIMEOUT cycles.
module hog_engine_arbiter #(
  parameter int REQ_AMT    = 2,
  parameter int CELL_WIDTH = 768,
  parameter int CELL_NUM   = 1200,
  parameter int ID_W       = (REQ_AMT > 1) ? $clog2(REQ_AMT) : 1,
  parameter int CNT_W      = (CELL_NUM > 1) ? $clog2(CELL_NUM) : 1,
  parameter int TIMEOUT    = 1024
) (
  input  logic                          s_aclk,
  input  logic                          s_areset,
  input  logic [REQ_AMT*CELL_WIDTH-1:0] req_cell_data_i,
  input  logic [REQ_AMT-1:0]            req_cell_valid_i,
  output logic [REQ_AMT-1:0]            req_cell_ready_o,
  output logic [CELL_WIDTH-1:0]         cell_data_o,
  output logic                          cell_valid_o,
  input  logic                          cell_ready_i,
  output logic [ID_W-1:0]               grant_id_o,
  output logic                          busy_o,
  output logic                          frame_done_o,
  output logic                          timeout_o
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic [ID_W-1:0] rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [ID_W:0]   pick;
  logic            hs;
  logic [CELL_WIDTH-1:0] sel_data;

`ifdef HOG_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_q, stall_d;
  logic          tmo_q, tmo_d;
`endif

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (int'(id) >= REQ_AMT - 1) next_id = '0;
    else                         next_id = id + ID_W'(1);
  endfunction

  // Walks offsets from the far end so the closest valid index to ptr wins.
  function automatic logic [ID_W:0] rr_pick(input logic [REQ_AMT-1:0] vld,
                                            input logic [ID_W-1:0]    ptr);
    int idx;
    rr_pick = '0;
    for (int i = REQ_AMT - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= REQ_AMT) idx = idx - REQ_AMT;
      if (vld[idx]) rr_pick = {1'b1, ID_W'(idx)};
    end
  endfunction

  assign pick     = rr_pick(req_cell_valid_i, rr_q);
  assign sel_data = req_cell_data_i[int'(grant_q)*CELL_WIDTH +: CELL_WIDTH];

  assign cell_valid_o = busy_q & req_cell_valid_i[grant_q];
  assign cell_data_o  = busy_q ? sel_data : '0;
  assign hs           = cell_valid_o & cell_ready_i;

  always_comb begin
    req_cell_ready_o = '0;
    for (int r = 0; r < REQ_AMT; r++) begin
      req_cell_ready_o[r] = busy_q & (int'(grant_q) == r) & cell_ready_i;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef HOG_ARB_TIMEOUT_EN
    stall_d = '0;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick[ID_W]) begin
          grant_d = pick[ID_W-1:0];
          busy_d  = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (hs) begin
          if (cnt_q == CNT_W'(CELL_NUM - 1)) begin
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef HOG_ARB_TIMEOUT_EN
        else if (stall_q == SW'(TIMEOUT - 1)) begin
          // Abort skips DONE: no completion pulse for a frame that never finished.
          cnt_d   = '0;
          busy_d  = 1'b0;
          tmo_d   = 1'b1;
          rr_d    = next_id(grant_q);
          state_d = IDLE;
        end else begin
          stall_d = stall_q + SW'(1);
        end
`endif
      end
      DONE: begin
        rr_d    = next_id(grant_q);
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef HOG_ARB_TIMEOUT_EN
      stall_q <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef HOG_ARB_TIMEOUT_EN
      stall_q <= stall_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign grant_id_o   = grant_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
`ifdef HOG_ARB_TIMEOUT_EN
  assign timeout_o    = tmo_q;
`else
  assign timeout_o    = 1'b0;
`endif

endmodule

// File: tb/tb_hog_engine_arbiter.sv
// Scoreboard bench for hog_engine_arbiter: expected grant order and per-source cell words are
// queued as stimulus is driven and consumed as the DUT grants frames and forwards cells.
module tb_hog_engine_arbiter;
  localparam int REQ_AMT    = 3;
  localparam int CELL_WIDTH = 16;
  localparam int CELL_NUM   = 4;
  localparam int TIMEOUT    = 16;
  localparam int ID_W       = 2;
  localparam int CNT_W      = 2;

  logic                          s_aclk = 1'b0;
  logic                          s_areset;
  logic [REQ_AMT*CELL_WIDTH-1:0] req_cell_data_i;
  logic [REQ_AMT-1:0]            req_cell_valid_i;
  logic [REQ_AMT-1:0]            req_cell_ready_o;
  logic [CELL_WIDTH-1:0]         cell_data_o;
  logic                          cell_valid_o;
  logic                          cell_ready_i;
  logic [ID_W-1:0]               grant_id_o;
  logic                          busy_o;
  logic                          frame_done_o;
  logic                          timeout_o;

  always #5 s_aclk = ~s_aclk;

  hog_engine_arbiter #(
    .REQ_AMT(REQ_AMT), .CELL_WIDTH(CELL_WIDTH), .CELL_NUM(CELL_NUM),
    .ID_W(ID_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .s_aclk(s_aclk), .s_areset(s_areset),
    .req_cell_data_i(req_cell_data_i), .req_cell_valid_i(req_cell_valid_i),
    .req_cell_ready_o(req_cell_ready_o), .cell_data_o(cell_data_o),
    .cell_valid_o(cell_valid_o), .cell_ready_i(cell_ready_i),
    .grant_id_o(grant_id_o), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .timeout_o(timeout_o)
  );

  int checks = 0;
  int errors = 0;

  logic [ID_W-1:0]       exp_grant_q[$];
  logic [CELL_WIDTH-1:0] dq0[$], dq1[$], dq2[$];
  int  seq [REQ_AMT];
  bit  rdy_rand, rdy_val;
  int  hs_cnt, done_cnt, tmo_cnt, gap;
  int  cur_grant;
  bit  prev_busy, prev_done, after_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CELL_WIDTH-1:0] word(input int r);
    logic [31:0] rv, sv;
    rv = r;
    sv = seq[r];
    return {rv[3:0], sv[11:0]};
  endfunction

  task automatic push_word(input int r);
    case (r)
      0: dq0.push_back(word(0));
      1: dq1.push_back(word(1));
      default: dq2.push_back(word(2));
    endcase
  endtask

  task automatic pop_word(input int r, output logic [CELL_WIDTH-1:0] v, output bit ok);
    ok = 1'b1;
    v  = '0;
    case (r)
      0: if (dq0.size() > 0) v = dq0.pop_front(); else ok = 1'b0;
      1: if (dq1.size() > 0) v = dq1.pop_front(); else ok = 1'b0;
      default: if (dq2.size() > 0) v = dq2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  task automatic monitor();
    logic [CELL_WIDTH-1:0] exp_w;
    bit ok;
    if (busy_o && !prev_busy) begin
      if (exp_grant_q.size() == 0) begin
        check_eq("unexpected_grant", grant_id_o, 32'hFFFF_FFFF);
        cur_grant = grant_id_o;
      end else begin
        cur_grant = exp_grant_q.pop_front();
        check_eq("grant", grant_id_o, cur_grant);
      end
      if (after_done) check_eq("frame_gap", gap, 2);
      after_done = 1'b0;
    end
    if (busy_o) begin
      check_eq("grant_hold", grant_id_o, cur_grant);
      check_eq("ready_route", req_cell_ready_o, cell_ready_i ? (32'd1 << cur_grant) : 32'd0);
      check_eq("valid_route", cell_valid_o, req_cell_valid_i[cur_grant]);
      if (cell_valid_o && cell_ready_i) begin
        pop_word(cur_grant, exp_w, ok);
        check_eq("data_queue_ok", ok, 1);
        check_eq("cell_data", cell_data_o, exp_w);
        hs_cnt++;
        seq[cur_grant]++;
        push_word(cur_grant);
      end
    end else begin
      check_eq("idle_outputs", {cell_valid_o, req_cell_ready_o, cell_data_o}, 0);
      gap++;
    end
    if (frame_done_o) begin
      check_eq("done_pulse_width", prev_done, 0);
      check_eq("frame_cells", hs_cnt, CELL_NUM);
      hs_cnt = 0;
      done_cnt++;
      after_done = 1'b1;
      gap = 1;
    end
    if (timeout_o) begin
      tmo_cnt++;
      hs_cnt = 0;
    end
    prev_busy = busy_o;
    prev_done = frame_done_o;
  endtask

  task automatic step();
    @(negedge s_aclk);
    cell_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    for (int r = 0; r < REQ_AMT; r++) req_cell_data_i[r*CELL_WIDTH +: CELL_WIDTH] = word(r);
    #1;
    monitor();
  endtask

  task automatic run_until_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      step();
      n++;
    end
    if (done_cnt < target) check_eq("frame_budget", done_cnt, target);
  endtask

  task automatic run_until_hs(input int target, input int budget);
    int n;
    n = 0;
    while (hs_cnt < target && n < budget) begin
      step();
      n++;
    end
    if (hs_cnt < target) check_eq("handshake_budget", hs_cnt, target);
  endtask

  task automatic drain(input int n);
    req_cell_valid_i = '0;
    repeat (n) step();
    after_done = 1'b0;
  endtask

  initial begin
    int base;
    s_areset = 1'b1;
    req_cell_valid_i = '0;
    req_cell_data_i = '0;
    cell_ready_i = 1'b1;
    rdy_rand = 1'b0;
    rdy_val = 1'b1;
    hs_cnt = 0; done_cnt = 0; tmo_cnt = 0; gap = 0; cur_grant = 0;
    prev_busy = 1'b0; prev_done = 1'b0; after_done = 1'b0;
    for (int r = 0; r < REQ_AMT; r++) begin
      seq[r] = 0;
      push_word(r);
    end

    repeat (2) step();
    check_eq("rst_grant", grant_id_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_done", frame_done_o, 0);
    check_eq("rst_timeout", timeout_o, 0);
    check_eq("rst_ready", req_cell_ready_o, 0);
    check_eq("rst_valid", cell_valid_o, 0);
    s_areset = 1'b0;

    // Single requester, engine always ready: grant after one cycle, back-to-back frames
    exp_grant_q.push_back(0);
    exp_grant_q.push_back(0);
    req_cell_valid_i = 3'b001;
    step();
    check_eq("arb_latency", busy_o, 1);
    run_until_done(2, 40);
    drain(3);

    // All three requesting: rr pointer sits at 1 after serving requester 0
    exp_grant_q.push_back(1);
    exp_grant_q.push_back(2);
    exp_grant_q.push_back(0);
    req_cell_valid_i = 3'b111;
    run_until_done(done_cnt + 3, 60);
    drain(3);

    // Random engine backpressure
    rdy_rand = 1'b1;
    exp_grant_q.push_back(1);
    exp_grant_q.push_back(2);
    req_cell_valid_i = 3'b111;
    run_until_done(done_cnt + 2, 200);
    rdy_rand = 1'b0;
    drain(3);

    // Async reset mid-frame on requester 1
    exp_grant_q.push_back(1);
    req_cell_valid_i = 3'b010;
    run_until_hs(2, 20);
    @(posedge s_aclk);
    #1;
    s_areset = 1'b1;
    #1;
    check_eq("arst_busy", busy_o, 0);
    check_eq("arst_valid", cell_valid_o, 0);
    check_eq("arst_ready", req_cell_ready_o, 0);
    check_eq("arst_grant", grant_id_o, 0);
    check_eq("arst_data", cell_data_o, 0);
    exp_grant_q.delete();
    hs_cnt = 0;
    prev_busy = 1'b0;
    after_done = 1'b0;
    repeat (2) step();
    s_areset = 1'b0;
    exp_grant_q.push_back(0);
    exp_grant_q.push_back(1);
    req_cell_valid_i = 3'b011;
    run_until_done(done_cnt + 2, 40);
    drain(3);

    // Only requester 2: re-granted each frame across the pointer wrap
    exp_grant_q.push_back(2);
    exp_grant_q.push_back(2);
    req_cell_valid_i = 3'b100;
    run_until_done(done_cnt + 2, 40);
    drain(3);

    // Engine stalls mid-frame
    exp_grant_q.push_back(0);
    req_cell_valid_i = 3'b011;
    run_until_hs(1, 20);
    rdy_val = 1'b0;
    base = done_cnt;
`ifdef HOG_ARB_TIMEOUT_EN
    exp_grant_q.push_back(1);
    repeat (20) step();
    check_eq("stall_timeout_pulses", tmo_cnt, 1);
    check_eq("stall_no_done", done_cnt, base);
    check_eq("stall_regrant_busy", busy_o, 1);
    check_eq("stall_regrant_id", grant_id_o, 1);
`else
    repeat (20) step();
    check_eq("stall_no_timeout", tmo_cnt, 0);
    check_eq("stall_timeout_o", timeout_o, 0);
    check_eq("stall_busy_held", busy_o, 1);
    check_eq("stall_grant_held", grant_id_o, 0);
    check_eq("stall_no_done", done_cnt, base);
`endif
    rdy_val = 1'b1;
    run_until_done(base + 1, 40);
    drain(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
